// File: rtl/montgomery_mult_rk.sv
// Radix-2^K Montgomery modular multiplier: result = A*B*2^-WIDTH mod M.
// K bits of A are retired per clock, followed by one conditional final subtract.
module montgomery_mult_rk #(
    parameter int WIDTH = 1024,
    parameter int K     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for start, ready=1
    // LOOP   | retiring K bits of A per cycle, WIDTH/K cycles
    // SUB    | final conditional subtract, result registered
    // DONE   | one-cycle done pulse, start accepted again

    localparam int N  = WIDTH / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((K != 1 && K != 2 && K != 4) || (WIDTH % K) != 0) begin : g_bad_param
        $error("montgomery_mult_rk: K must be 1, 2 or 4 and divide WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_SUB, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, m_reg;
    logic [WIDTH+1:0] c_reg, c_step;
    logic [CW-1:0]    count;
    logic             accept;
    logic             borrow;
    logic [WIDTH-1:0] c_minus_m;

    assign accept = ready & start;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOOP;
            S_LOOP: if (count == LAST) state_nxt = S_SUB;
            S_SUB:  state_nxt = S_DONE;
            S_DONE: state_nxt = start ? S_LOOP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_LOOP: busy  = 1'b1;
            S_SUB:  busy  = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // C < 2M is kept after every sub-step, so WIDTH+2 bits never overflow
    always_comb begin
        c_step = c_reg;
        for (int j = 0; j < K; j++) begin
            if (a_reg[j]) c_step = c_step + {2'b00, b_reg};
            if (c_step[0]) c_step = c_step + {2'b00, m_reg};
            c_step = c_step >> 1;
        end
    end

    // low bits of C-M match the truncated difference; the borrow is the full compare
    assign borrow    = c_reg < {2'b00, m_reg};
    assign c_minus_m = c_reg[WIDTH-1:0] - m_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            c_reg  <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
                m_reg <= in_m;
                c_reg <= '0;
                count <= '0;
            end else if (state == S_LOOP) begin
                c_reg <= c_step;
                a_reg <= a_reg >> K;
                count <= count + 1'b1;
            end
            if (state == S_SUB) result <= borrow ? c_reg[WIDTH-1:0] : c_minus_m;
        end
    end

endmodule

// File: tb/tb_montgomery_mult_rk.sv
// Scoreboard bench for montgomery_mult_rk: 8-bit instances for K=1,2,4 and
// 1024-bit instances for K=2,4 checked against an independent modular-arithmetic model.
module tb_montgomery_mult_rk;

    logic        clk;
    logic        reset;
    logic [7:0]  a8, b8, m8;
    logic        start8 [3];
    logic        ready8 [3];
    logic        busy8  [3];
    logic        done8  [3];
    logic [7:0]  res8   [3];

    logic [1023:0] a_w, b_w, m_w;
    logic          start_w [2];
    logic          ready_w [2];
    logic          busy_w  [2];
    logic          done_w  [2];
    logic [1023:0] res_w   [2];

    int errors = 0;
    int checks = 0;
    int kv [3] = '{1, 2, 4};

    logic [7:0]    exp_q8 [$];
    logic [1023:0] exp_qw [$];

    montgomery_mult_rk #(.WIDTH(8), .K(1)) u_w8_k1 (
        .clk(clk), .reset(reset), .start(start8[0]), .in_a(a8), .in_b(b8), .in_m(m8),
        .ready(ready8[0]), .busy(busy8[0]), .result(res8[0]), .done(done8[0]));
    montgomery_mult_rk #(.WIDTH(8), .K(2)) u_w8_k2 (
        .clk(clk), .reset(reset), .start(start8[1]), .in_a(a8), .in_b(b8), .in_m(m8),
        .ready(ready8[1]), .busy(busy8[1]), .result(res8[1]), .done(done8[1]));
    montgomery_mult_rk #(.WIDTH(8), .K(4)) u_w8_k4 (
        .clk(clk), .reset(reset), .start(start8[2]), .in_a(a8), .in_b(b8), .in_m(m8),
        .ready(ready8[2]), .busy(busy8[2]), .result(res8[2]), .done(done8[2]));
    montgomery_mult_rk #(.WIDTH(1024), .K(2)) u_w1024_k2 (
        .clk(clk), .reset(reset), .start(start_w[0]), .in_a(a_w), .in_b(b_w), .in_m(m_w),
        .ready(ready_w[0]), .busy(busy_w[0]), .result(res_w[0]), .done(done_w[0]));
    montgomery_mult_rk #(.WIDTH(1024), .K(4)) u_w1024_k4 (
        .clk(clk), .reset(reset), .start(start_w[1]), .in_a(a_w), .in_b(b_w), .in_m(m_w),
        .ready(ready_w[1]), .busy(busy_w[1]), .result(res_w[1]), .done(done_w[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // R with R*2^8 == A*B (mod M), found by search rather than by the Montgomery recurrence
    function automatic logic [7:0] mont8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int ab;
        ab = (int'(a) * int'(b)) % int'(m);
        for (int r = 0; r < int'(m); r++)
            if ((r * 256) % int'(m) == ab) return 8'(r);
        return 8'h00;
    endfunction

    function automatic logic [1023:0] mulmod(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m);
        logic [1025:0] r;
        logic [1025:0] mm;
        r  = '0;
        mm = {2'b00, m};
        for (int i = 1023; i >= 0; i--) begin
            r = r << 1;
            if (r >= mm) r = r - mm;
            if (b[i]) begin
                r = r + {2'b00, a};
                if (r >= mm) r = r - mm;
            end
        end
        return r[1023:0];
    endfunction

    // R * 2^1024 mod M, used to map a Montgomery result back to A*B mod M
    function automatic logic [1023:0] scale_up(input logic [1023:0] r, input logic [1023:0] m);
        logic [1025:0] x;
        logic [1025:0] mm;
        mm = {2'b00, m};
        x  = {2'b00, r % m};
        for (int i = 0; i < 1024; i++) begin
            x = x << 1;
            if (x >= mm) x = x - mm;
        end
        return x[1023:0];
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic run8(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        int         cyc;
        logic [7:0] exp_v;
        exp_q8.push_back(e);
        a8 = a;
        b8 = b;
        start8[k] = 1'b1;
        step();
        start8[k] = 1'b0;
        a8 = ~a;
        b8 = ~b;
        cyc = 1;
        checks++;
        if (busy8[k] !== 1'b1 || ready8[k] !== 1'b0) begin
            errors++;
            $display("FAIL accept_flags k=%0d busy=%b ready=%b required busy=1 ready=0", kv[k], busy8[k], ready8[k]);
        end
        while (done8[k] !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        exp_v = exp_q8.pop_front();
        checks++;
        if (done8[k] !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout k=%0d a=%h b=%h no done after %0d cycles", kv[k], a, b, cyc);
        end else begin
            checks++;
            if (res8[k] !== exp_v) begin
                errors++;
                $display("FAIL result8 k=%0d m=%h a=%h b=%h got=%h required=%h", kv[k], m8, a, b, res8[k], exp_v);
            end
            if (cyc != 8 / kv[k] + 2) begin
                errors++;
                $display("FAIL latency8 k=%0d got=%0d required=%0d", kv[k], cyc, 8 / kv[k] + 2);
            end
        end
        step();
        checks++;
        if (done8[k] !== 1'b0 || ready8[k] !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse k=%0d done=%b ready=%b required done=0 ready=1", kv[k], done8[k], ready8[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ready8[i], busy8[i], done8[i], res8[i]} !== {3'b100, 8'h00}) begin
                errors++;
                $display("FAIL reset8 k=%0d ready=%b busy=%b done=%b result=%h required 1 0 0 00",
                         kv[i], ready8[i], busy8[i], done8[i], res8[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ready_w[i], busy_w[i], done_w[i]} !== 3'b100 || res_w[i] !== '0) begin
                errors++;
                $display("FAIL reset1024 idx=%0d ready=%b busy=%b done=%b required 1 0 0 result=0",
                         i, ready_w[i], busy_w[i], done_w[i]);
            end
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_spec_vectors();
        logic [7:0] va [4] = '{8'h05, 8'hEE, 8'h01, 8'h00};
        logic [7:0] vb [4] = '{8'h07, 8'hEE, 8'h11, 8'h55};
        logic [7:0] ve [4] = '{8'hE3, 8'hE1, 8'h01, 8'h00};
        m8 = 8'hEF;
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++)
                run8(k, va[v], vb[v], ve[v]);
    endtask

    task automatic test_random8();
        logic [7:0] m, a, b;
        for (int v = 0; v < 8; v++) begin
            m  = 8'($urandom_range(3, 255)) | 8'h01;
            a  = 8'($urandom_range(0, int'(m) - 1));
            b  = 8'($urandom_range(0, int'(m) - 1));
            m8 = m;
            run8(v % 3, a, b, mont8(a, b, m));
        end
        m8 = 8'hEF;
    endtask

    task automatic test_start_during_loop();
        int         ndone;
        logic [7:0] got;
        logic [7:0] exp_v;
        m8 = 8'hEF;
        exp_q8.push_back(8'hE3);
        a8 = 8'h05;
        b8 = 8'h07;
        start8[1] = 1'b1;
        step();
        start8[1] = 1'b0;
        step();
        a8 = 8'h55;
        b8 = 8'h33;
        start8[1] = 1'b1;
        step();
        start8[1] = 1'b0;
        ndone = 0;
        got   = 8'h00;
        for (int i = 0; i < 30; i++) begin
            if (done8[1] === 1'b1) begin
                ndone++;
                got = res8[1];
            end
            step();
        end
        exp_v = exp_q8.pop_front();
        checks++;
        if (ndone != 1 || got !== exp_v) begin
            errors++;
            $display("FAIL start_in_loop done_count=%0d result=%h required 1 pulse result=%h", ndone, got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        logic [7:0] exp_v;
        m8 = 8'hEF;
        exp_q8.push_back(8'hE3);
        exp_q8.push_back(8'hE1);
        a8 = 8'h05;
        b8 = 8'h07;
        start8[1] = 1'b1;
        step();
        start8[1] = 1'b0;
        cyc = 1;
        while (done8[1] !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        exp_v = exp_q8.pop_front();
        checks++;
        if (done8[1] !== 1'b1 || res8[1] !== exp_v) begin
            errors++;
            $display("FAIL b2b_first done=%b result=%h required done=1 result=%h", done8[1], res8[1], exp_v);
        end
        a8 = 8'hEE;
        b8 = 8'hEE;
        start8[1] = 1'b1;
        step();
        start8[1] = 1'b0;
        cyc = 1;
        while (done8[1] !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        exp_v = exp_q8.pop_front();
        checks++;
        if (done8[1] !== 1'b1 || cyc != 6 || res8[1] !== exp_v) begin
            errors++;
            $display("FAIL b2b_second done=%b spacing=%0d result=%h required done=1 spacing=6 result=%h",
                     done8[1], cyc, res8[1], exp_v);
        end
        step();
    endtask

    task automatic test_reset_mid_loop();
        m8 = 8'hEF;
        a8 = 8'h01;
        b8 = 8'h03;
        start8[1] = 1'b1;
        step();
        start8[1] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({done8[1], busy8[1], ready8[1]} !== 3'b001 || res8[1] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_loop done=%b busy=%b ready=%b result=%h required 0 0 1 00",
                     done8[1], busy8[1], ready8[1], res8[1]);
        end
        reset = 1'b1;
        start8[1] = 1'b1;
        step();
        reset = 1'b0;
        start8[1] = 1'b0;
        step();
        checks++;
        if (busy8[1] !== 1'b0 || ready8[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority busy=%b ready=%b required busy=0 ready=1", busy8[1], ready8[1]);
        end
        run8(1, 8'h05, 8'h07, 8'hE3);
    endtask

    task automatic test_wide();
        logic [1023:0] m, a, b, r2, r4, e;
        int            cyc, c2, c4;
        for (int v = 0; v < 60; v++) begin
            m = rand1024() | 1024'd1;
            if (v % 2 == 0) m[1023] = 1'b1;
            if (m == 1024'd1) m = 1024'd3;
            a = (v == 0) ? '0 : rand1024() % m;
            b = rand1024() % m;
            e = mulmod(a, b, m);
            exp_qw.push_back(e);
            exp_qw.push_back(e);
            a_w = a;
            b_w = b;
            m_w = m;
            start_w[0] = 1'b1;
            start_w[1] = 1'b1;
            step();
            start_w[0] = 1'b0;
            start_w[1] = 1'b0;
            a_w = ~a;
            b_w = ~b;
            m_w = '0;
            cyc = 1;
            c2  = 0;
            c4  = 0;
            r2  = '0;
            r4  = '0;
            while ((c2 == 0 || c4 == 0) && cyc < 700) begin
                step();
                cyc++;
                if (done_w[0] === 1'b1 && c2 == 0) begin c2 = cyc; r2 = res_w[0]; end
                if (done_w[1] === 1'b1 && c4 == 0) begin c4 = cyc; r4 = res_w[1]; end
            end
            checks++;
            if (c2 != 514 || c4 != 258) begin
                errors++;
                $display("FAIL latency1024 v=%0d k2=%0d k4=%0d required 514 258", v, c2, c4);
            end
            e = exp_qw.pop_front();
            checks++;
            if (r2 >= m || scale_up(r2, m) !== e) begin
                errors++;
                $display("FAIL result1024_k2 v=%0d result_lo=%h abmodm_lo=%h", v, r2[63:0], e[63:0]);
            end
            e = exp_qw.pop_front();
            checks++;
            if (r4 >= m || scale_up(r4, m) !== e) begin
                errors++;
                $display("FAIL result1024_k4 v=%0d result_lo=%h abmodm_lo=%h", v, r4[63:0], e[63:0]);
            end
            step();
        end
    endtask

    initial begin
        reset   = 1'b1;
        start8  = '{1'b0, 1'b0, 1'b0};
        start_w = '{1'b0, 1'b0};
        a8 = '0; b8 = '0; m8 = 8'hEF;
        a_w = '0; b_w = '0; m_w = '0;
        test_reset();
        test_spec_vectors();
        test_random8();
        test_start_during_loop();
        test_back_to_back();
        test_reset_mid_loop();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
